// File: rtl/audio_waveshaper_os_if.sv
// ============================================================================
//  Module      : audio_waveshaper_os_if
//  Description : Sample and control bundle for the oversampled waveshaper.
//                The master side supplies drive, mode and input samples.
//                The slave side (the shaper) returns the decimated samples
//                and its status flags.
//  Signals     : pot_drive[9:0]        drive amount, gain = (64+pot_drive)/64
//                mode[1:0]             0 bypass, 1 hard, 2 soft, 3 fold
//                sample_in[WIDTH-1:0]  signed input sample
//                sample_in_valid       one-cycle input strobe
//                sample_out[WIDTH-1:0] signed decimated output sample
//                sample_out_valid      one-cycle output strobe
//                sample_dropped        pulse when an input strobe is ignored
//                busy                  generator is emitting sub-samples
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface audio_waveshaper_os_if #(
  parameter int WIDTH = 16
);
  logic [9:0]              pot_drive;
  logic [1:0]              mode;
  logic signed [WIDTH-1:0] sample_in;
  logic                    sample_in_valid;
  logic signed [WIDTH-1:0] sample_out;
  logic                    sample_out_valid;
  logic                    sample_dropped;
  logic                    busy;

  modport master (
    output pot_drive, mode, sample_in, sample_in_valid,
    input  sample_out, sample_out_valid, sample_dropped, busy
  );

  modport slave (
    input  pot_drive, mode, sample_in, sample_in_valid,
    output sample_out, sample_out_valid, sample_dropped, busy
  );
endinterface

`default_nettype wire

// File: rtl/audio_waveshaper_os.sv
// ============================================================================
//  Module      : audio_waveshaper_os
//  Description : Oversampled distortion stage. Each accepted sample is
//                linearly interpolated into RATIO sub-samples, each
//                sub-sample is driven through a selectable waveshaper
//                (bypass / hard clip / cubic soft clip / single fold), and
//                the shaped sub-samples are boxcar-averaged back to the
//                input rate.
//  Ports       : clk  system clock
//                rst  asynchronous reset, active low
//                bus  audio_waveshaper_os_if.slave (samples, drive, mode,
//                     output strobe, dropped flag, busy)
//  Latency     : sample_out_valid on cycle RATIO+4 after the accept edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_waveshaper_os #(
  parameter int WIDTH = 16,
  parameter int RATIO = 4
) (
  input  logic                clk,
  input  logic                rst,
  audio_waveshaper_os_if.slave bus
);

  localparam int LOG2R = $clog2(RATIO);
  localparam int KW    = (LOG2R > 0) ? LOG2R : 1;  // sub-sample index width
  localparam int DW    = WIDTH + 1;                // interpolation difference
  localparam int IW    = WIDTH + KW + 3;           // (k+1)*diff product
  localparam int PREW  = WIDTH + 11;               // gained sample
  localparam int MW    = WIDTH + 12;               // u * gain product
  localparam int CW    = 3 * (WIDTH + 1);          // full-precision cube
  localparam int AW    = WIDTH + LOG2R;            // decimator accumulator

  localparam logic [KW-1:0]          c_K_LAST = KW'(RATIO - 1);
  localparam logic signed [PREW-1:0] c_FS     = PREW'((longint'(1) <<< (WIDTH - 1)) - 1);
  localparam logic signed [PREW-1:0] c_NFS    = -c_FS;
  localparam logic signed [PREW-1:0] c_MIN    = -c_FS - PREW'(1);
  localparam logic signed [PREW-1:0] c_2FS    = c_FS + c_FS;
  localparam logic signed [PREW-1:0] c_N2MIN  = c_MIN + c_MIN;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Generator
  // --------------------------------------------------------------------------
  state_t                  r_state, w_state_nxt;
  logic [KW-1:0]           r_k, w_k_nxt;
  logic signed [WIDTH-1:0] r_x_new, r_x_prev;
  logic [9:0]              r_drive;
  logic [1:0]              r_mode;
  logic                    r_dropped;
  logic                    w_accept, w_sub_valid, w_sub_first, w_sub_last;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_accept    = 1'b0;
    w_sub_valid = 1'b0;
    w_sub_first = 1'b0;
    w_sub_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.sample_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
          w_k_nxt     = '0;
        end
      end
      ST_RUN: begin
        w_sub_valid = 1'b1;
        w_sub_first = (r_k == '0);
        w_sub_last  = (r_k == c_K_LAST);
        if (w_sub_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_k_nxt = r_k + KW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_x_new   <= '0;
      r_x_prev  <= '0;
      r_drive   <= '0;
      r_mode    <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      // A strobe seen while RUN is ignored, including on RUN's final edge.
      r_dropped <= (r_state == ST_RUN) && bus.sample_in_valid;
      if (w_accept) begin
        r_x_new <= bus.sample_in;
        r_drive <= bus.pot_drive;
        r_mode  <= bus.mode;
      end
      if (w_sub_last) begin
        r_x_prev <= r_x_new;
      end
    end
  end

  // u_k = x_prev + floor((k+1)*(x_new-x_prev) / RATIO); k = RATIO-1 yields x_new.
  logic signed [DW-1:0]    w_diff;
  logic signed [KW+1:0]    w_kp1;
  logic signed [IW-1:0]    w_prod;
  logic signed [WIDTH-1:0] w_u;

  assign w_diff = DW'(r_x_new) - DW'(r_x_prev);
  assign w_kp1  = $signed({1'b0, {1'b0, r_k} + (KW + 1)'(1)});
  assign w_prod = IW'(w_diff) * IW'(w_kp1);
  assign w_u    = WIDTH'(IW'(r_x_prev) + (w_prod >>> LOG2R));

  // --------------------------------------------------------------------------
  // S1: apply drive gain (64+drive)/64 at full precision
  // --------------------------------------------------------------------------
  logic signed [11:0]      w_gain;
  logic signed [MW-1:0]    w_mul;
  logic                    r1_valid, r1_first, r1_last;
  logic [1:0]              r1_mode;
  logic signed [WIDTH-1:0] r1_u;
  logic signed [PREW-1:0]  r1_pre;

  assign w_gain = $signed({1'b0, 11'd64 + {1'b0, r_drive}});
  assign w_mul  = MW'(w_u) * MW'(w_gain);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_valid <= 1'b0;
      r1_first <= 1'b0;
      r1_last  <= 1'b0;
      r1_mode  <= '0;
      r1_u     <= '0;
      r1_pre   <= '0;
    end else begin
      r1_valid <= w_sub_valid;
      r1_first <= w_sub_first;
      r1_last  <= w_sub_last;
      r1_mode  <= r_mode;
      r1_u     <= w_u;
      r1_pre   <= PREW'(w_mul >>> 6);
    end
  end

  // --------------------------------------------------------------------------
  // S2: shape selection (unsaturated, PREW bits)
  // --------------------------------------------------------------------------
  logic signed [DW-1:0]   w_c;
  logic signed [CW-1:0]   w_cube;
  logic signed [PREW-1:0] w_soft, w_fold, w_shape;
  logic                   r2_valid, r2_first, r2_last;
  logic signed [PREW-1:0] r2_y;

  always_comb begin
    w_c = DW'(r1_pre);
    if (r1_pre > c_FS) begin
      w_c = DW'(c_FS);
    end else if (r1_pre < c_NFS) begin
      w_c = DW'(c_NFS);
    end
  end

  // y = 1.5c - c^3 / 2^(2*WIDTH-1); the cube keeps every bit.
  assign w_cube = CW'(w_c) * CW'(w_c) * CW'(w_c);
  assign w_soft = PREW'(w_c) + PREW'(w_c >>> 1) - PREW'(w_cube >>> (2 * WIDTH - 1));

  // Single reflection about the positive or negative rail.
  always_comb begin
    w_fold = r1_pre;
    if (r1_pre > c_FS) begin
      w_fold = c_2FS - r1_pre;
    end else if (r1_pre < c_MIN) begin
      w_fold = c_N2MIN - r1_pre;
    end
  end

  always_comb begin
    w_shape = w_fold;
    case (r1_mode)
      2'd0:    w_shape = PREW'(r1_u);
      2'd1:    w_shape = r1_pre;
      2'd2:    w_shape = w_soft;
      default: w_shape = w_fold;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r2_valid <= 1'b0;
      r2_first <= 1'b0;
      r2_last  <= 1'b0;
      r2_y     <= '0;
    end else begin
      r2_valid <= r1_valid;
      r2_first <= r1_first;
      r2_last  <= r1_last;
      r2_y     <= w_shape;
    end
  end

  // --------------------------------------------------------------------------
  // S3: saturate to WIDTH bits
  // --------------------------------------------------------------------------
  logic signed [WIDTH-1:0] w_sat;
  logic                    r3_valid, r3_first, r3_last;
  logic signed [WIDTH-1:0] r3_y;

  always_comb begin
    w_sat = WIDTH'(r2_y);
    if (r2_y > c_FS) begin
      w_sat = WIDTH'(c_FS);
    end else if (r2_y < c_MIN) begin
      w_sat = WIDTH'(c_MIN);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r3_valid <= 1'b0;
      r3_first <= 1'b0;
      r3_last  <= 1'b0;
      r3_y     <= '0;
    end else begin
      r3_valid <= r2_valid;
      r3_first <= r2_first;
      r3_last  <= r2_last;
      r3_y     <= w_sat;
    end
  end

  // --------------------------------------------------------------------------
  // Decimator: tags, not timing, decide load vs. accumulate, so overlapping
  // groups in the pipeline never mix.
  // --------------------------------------------------------------------------
  logic signed [AW-1:0]    r_acc, w_sum;
  logic signed [WIDTH-1:0] r_out;
  logic                    r_out_valid;

  assign w_sum = (r3_first ? AW'(0) : r_acc) + AW'(r3_y);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r3_valid && r3_last;
      if (r3_valid) begin
        r_acc <= w_sum;
        if (r3_last) begin
          r_out <= WIDTH'(w_sum >>> LOG2R);
        end
      end
    end
  end

  assign bus.sample_out       = r_out;
  assign bus.sample_out_valid = r_out_valid;
  assign bus.sample_dropped   = r_dropped;
  assign bus.busy             = (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_audio_waveshaper_os.sv
// ============================================================================
//  Module      : tb_audio_waveshaper_os
//  Description : Directed self-checking bench for audio_waveshaper_os with
//                WIDTH=16, RATIO=4. Expected values are hand-computed.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_waveshaper_os;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  audio_waveshaper_os_if #(.WIDTH(16)) bus ();

  audio_waveshaper_os #(.WIDTH(16), .RATIO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus schedule: strobe st_val[i] so that it is sampled on edge st_cyc[i].
  int          st_n;
  int          st_cyc [8];
  logic [15:0] st_val [8];

  // Observations; index c is "cycle c" counted from edge 0.
  int          out_n, drop_n, drop_cyc;
  int          out_cyc [8];
  logic [15:0] out_val [8];
  logic        busy_log [32];

  task automatic run_window(input int ncyc);
    out_n    = 0;
    drop_n   = 0;
    drop_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      out_cyc[i] = -1;
      out_val[i] = 16'hxxxx;
    end
    for (int c = 0; c < ncyc; c++) begin
      if (bus.sample_out_valid === 1'b1) begin
        if (out_n < 8) begin
          out_cyc[out_n] = c;
          out_val[out_n] = bus.sample_out;
        end
        out_n++;
      end
      if (bus.sample_dropped === 1'b1) begin
        if (drop_n == 0) drop_cyc = c;
        drop_n++;
      end
      busy_log[c] = bus.busy;
      bus.sample_in_valid = 1'b0;
      for (int i = 0; i < st_n; i++) begin
        if (st_cyc[i] == c) begin
          bus.sample_in       = st_val[i];
          bus.sample_in_valid = 1'b1;
        end
      end
      @(negedge clk);
    end
    bus.sample_in_valid = 1'b0;
  endtask

  task automatic steady(input logic [15:0] x);
    st_n = 2;
    st_cyc[0] = 0; st_val[0] = x;
    st_cyc[1] = 5; st_val[1] = x;
    run_window(18);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (bus.sample_out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_out: got %h expected 0000", bus.sample_out);
    end
    n_checks++;
    if (bus.sample_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.sample_out_valid);
    end
    n_checks++;
    if (bus.sample_dropped !== 1'b0) begin
      n_fail++; $display("FAIL reset_dropped: got %b expected 0", bus.sample_dropped);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_linear;
    bus.mode = 2'd0; bus.pot_drive = 10'd0;
    st_n = 1; st_cyc[0] = 0; st_val[0] = 16'h1000;
    run_window(14);
    n_checks++;
    if (out_n !== 1) begin
      n_fail++; $display("FAIL linear_count: got %0d expected 1", out_n);
    end
    n_checks++;
    if (out_cyc[0] !== 8) begin
      n_fail++; $display("FAIL linear_latency: got %0d expected 8", out_cyc[0]);
    end
    n_checks++;
    if (out_val[0] !== 16'h0A00) begin
      n_fail++; $display("FAIL linear_value: got %h expected 0a00", out_val[0]);
    end
    n_checks++;
    if (busy_log[0] !== 1'b0) begin
      n_fail++; $display("FAIL linear_busy_c0: got %b expected 0", busy_log[0]);
    end
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (busy_log[c] !== 1'b1) begin
        n_fail++; $display("FAIL linear_busy_c%0d: got %b expected 1", c, busy_log[c]);
      end
    end
    n_checks++;
    if (busy_log[5] !== 1'b0) begin
      n_fail++; $display("FAIL linear_busy_c5: got %b expected 0", busy_log[5]);
    end
    n_checks++;
    if (bus.sample_out !== 16'h0A00) begin
      n_fail++; $display("FAIL linear_hold: got %h expected 0a00", bus.sample_out);
    end
  endtask

  task automatic test_hard_clip;
    bus.mode = 2'd1; bus.pot_drive = 10'd1023;
    steady(16'h4000);
    n_checks++;
    if (out_n !== 2 || out_cyc[1] !== 13) begin
      n_fail++; $display("FAIL hard_timing: got n=%0d cyc=%0d expected n=2 cyc=13", out_n, out_cyc[1]);
    end
    n_checks++;
    if (out_val[1] !== 16'h7FFF) begin
      n_fail++; $display("FAIL hard_pos: got %h expected 7fff", out_val[1]);
    end
    steady(16'hC000);
    n_checks++;
    if (out_val[1] !== 16'h8000) begin
      n_fail++; $display("FAIL hard_neg: got %h expected 8000", out_val[1]);
    end
  endtask

  task automatic test_soft_clip;
    bus.mode = 2'd2; bus.pot_drive = 10'd0;
    steady(16'h2000);
    n_checks++;
    if (out_val[1] !== 16'h2F00) begin
      n_fail++; $display("FAIL soft_mid: got %h expected 2f00", out_val[1]);
    end
    steady(16'h7FFF);
    n_checks++;
    if (out_val[1] !== 16'h7FFF) begin
      n_fail++; $display("FAIL soft_full: got %h expected 7fff", out_val[1]);
    end
  endtask

  task automatic test_fold;
    bus.mode = 2'd3; bus.pot_drive = 10'd64;
    steady(16'h6000);
    n_checks++;
    if (out_val[1] !== 16'h3FFE) begin
      n_fail++; $display("FAIL fold_over: got %h expected 3ffe", out_val[1]);
    end
    steady(16'h1000);
    n_checks++;
    if (out_val[1] !== 16'h2000) begin
      n_fail++; $display("FAIL fold_linear: got %h expected 2000", out_val[1]);
    end
  endtask

  task automatic test_drop;
    bus.mode = 2'd0; bus.pot_drive = 10'd0;
    // Strobe in the middle of RUN.
    st_n = 2;
    st_cyc[0] = 0; st_val[0] = 16'h1000;
    st_cyc[1] = 2; st_val[1] = 16'h7000;
    run_window(14);
    n_checks++;
    if (drop_n !== 1 || drop_cyc !== 3) begin
      n_fail++; $display("FAIL drop_mid_pulse: got n=%0d cyc=%0d expected n=1 cyc=3", drop_n, drop_cyc);
    end
    n_checks++;
    if (out_n !== 1 || out_val[0] !== 16'h1000) begin
      n_fail++; $display("FAIL drop_mid_out: got n=%0d val=%h expected n=1 val=1000", out_n, out_val[0]);
    end
    // Strobe on the edge where RUN ends.
    st_cyc[1] = 4;
    run_window(14);
    n_checks++;
    if (drop_n !== 1 || drop_cyc !== 5) begin
      n_fail++; $display("FAIL drop_end_pulse: got n=%0d cyc=%0d expected n=1 cyc=5", drop_n, drop_cyc);
    end
    n_checks++;
    if (out_n !== 1 || out_val[0] !== 16'h1000) begin
      n_fail++; $display("FAIL drop_end_out: got n=%0d val=%h expected n=1 val=1000", out_n, out_val[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_val [4];
    exp_val[0] = 16'h1A00;  // 0x1000 -> 0x2000
    exp_val[1] = 16'h0C00;  // 0x2000 -> 0x0000
    exp_val[2] = 16'h00A0;  // 0x0000 -> 0x0100
    exp_val[3] = 16'h005D;  // 0x0100 -> -3, floor on negative steps
    bus.mode = 2'd0; bus.pot_drive = 10'd0;
    st_n = 4;
    st_cyc[0] = 0;  st_val[0] = 16'h2000;
    st_cyc[1] = 5;  st_val[1] = 16'h0000;
    st_cyc[2] = 10; st_val[2] = 16'h0100;
    st_cyc[3] = 15; st_val[3] = 16'hFFFD;
    run_window(28);
    n_checks++;
    if (out_n !== 4 || drop_n !== 0) begin
      n_fail++; $display("FAIL b2b_counts: got outs=%0d drops=%0d expected outs=4 drops=0", out_n, drop_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_cyc[i] !== 8 + 5 * i) begin
        n_fail++; $display("FAIL b2b_cyc%0d: got %0d expected %0d", i, out_cyc[i], 8 + 5 * i);
      end
      n_checks++;
      if (out_val[i] !== exp_val[i]) begin
        n_fail++; $display("FAIL b2b_val%0d: got %h expected %h", i, out_val[i], exp_val[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    bus.mode = 2'd0; bus.pot_drive = 10'd0;
    st_n = 1; st_cyc[0] = 0; st_val[0] = 16'h7000;
    run_window(3);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", bus.busy);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.sample_out !== 16'h0000 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_clear: got out=%h busy=%b expected out=0000 busy=0", bus.sample_out, bus.busy);
    end
    n_checks++;
    if (bus.sample_out_valid !== 1'b0 || bus.sample_dropped !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags: got valid=%b dropped=%b expected 0 0", bus.sample_out_valid, bus.sample_dropped);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    st_n = 0;
    run_window(12);
    n_checks++;
    if (out_n !== 0) begin
      n_fail++; $display("FAIL rstmid_no_output: got %0d expected 0", out_n);
    end
    st_n = 1; st_cyc[0] = 0; st_val[0] = 16'h1000;
    run_window(14);
    n_checks++;
    if (out_n !== 1 || out_cyc[0] !== 8) begin
      n_fail++; $display("FAIL rstmid_after_timing: got n=%0d cyc=%0d expected n=1 cyc=8", out_n, out_cyc[0]);
    end
    n_checks++;
    if (out_val[0] !== 16'h0A00) begin
      n_fail++; $display("FAIL rstmid_after_value: got %h expected 0a00", out_val[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_in       = '0;
    bus.sample_in_valid = 1'b0;
    bus.pot_drive       = '0;
    bus.mode            = '0;
    st_n                = 0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_linear();
    test_hard_clip();
    test_soft_clip();
    test_fold();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
